// File: rtl/controller.sv
// ============================================================================
// Module      : controller
// Description : Multi-cycle fetch/decode/execute/writeback sequencer that
//               drives the regfile, ALU and memory port of a 16-bit datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller #(
  parameter logic [15:0] P_RESET_PC   = 16'h0000,
  parameter logic [3:0]  P_CMP_OPCODE = 4'b1011
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_MEM_DATA,
  input  logic [15:0] I_REG_A_DATA,
  input  logic [15:0] I_REG_B_DATA,
  input  logic [4:0]  I_STATUS_FLAGS,
  output logic [15:0] O_MEM_ADDRESS,
  output logic        O_MEM_WRITE_ENABLE,
  output logic [15:0] O_MEM_WRITE_DATA,
  output logic [15:0] O_REG_WRITE_ENABLE,
  output logic [3:0]  O_REG_A_SELECT,
  output logic [3:0]  O_REG_B_SELECT,
  output logic [15:0] O_IMMEDIATE,
  output logic        O_IMMEDIATE_SELECT,
  output logic [3:0]  O_OPCODE,
  output logic        O_REGFILE_DATA_SELECT,
  output logic        O_DATAPATH_ENABLE,
  output logic [15:0] O_PC,
  output logic [4:0]  O_FLAGS,
  output logic [1:0]  O_STATE
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] c_OP_RTYPE = 4'b0000;
  localparam logic [3:0] c_OP_LOAD  = 4'b1000;
  localparam logic [3:0] c_OP_STORE = 4'b1001;
  localparam logic [3:0] c_OP_BCOND = 4'b1100;
  localparam logic [3:0] c_OP_JCOND = 4'b1110;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [4:0]  r_psr;

  logic [15:0] w_pc_next;
  logic        w_psr_load;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_dp_enable;
  logic        w_cond;
  logic        w_active;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_ext;
  logic [3:0]  w_rs;
  logic [15:0] w_simm;
  logic [15:0] w_pc_inc;
  logic [3:0]  w_alu_opcode;

  assign w_op         = r_ir[15:12];
  assign w_rd         = r_ir[11:8];
  assign w_ext        = r_ir[7:4];
  assign w_rs         = r_ir[3:0];
  assign w_simm       = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_pc_inc     = r_pc + 16'd1;
  assign w_alu_opcode = (w_op == c_OP_RTYPE) ? w_ext : {1'b0, w_op[2:0]};

  // Condition is taken from the latched PSR, so it reflects flags as they
  // stood when EXECUTE began.
  always_comb begin
    w_cond = 1'b0;
    case (w_rd)
      4'd0:    w_cond =  r_psr[1];
      4'd1:    w_cond = ~r_psr[1];
      4'd2:    w_cond =  r_psr[4];
      4'd3:    w_cond = ~r_psr[4];
      4'd4:    w_cond =  r_psr[3];
      4'd5:    w_cond = ~r_psr[3];
      4'd6:    w_cond =  r_psr[0];
      4'd7:    w_cond = ~r_psr[0];
      4'd8:    w_cond =  r_psr[2];
      4'd9:    w_cond = ~r_psr[2];
      4'd14:   w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state <= S_FETCH;
      r_pc    <= P_RESET_PC;
      r_ir    <= 16'h0000;
      r_psr   <= 5'b00000;
    end else if (I_ENABLE) begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (r_state == S_DECODE) begin
        r_ir <= I_MEM_DATA;
      end
      if (w_psr_load) begin
        r_psr <= I_STATUS_FLAGS;
      end
    end
  end

  always_comb begin
    w_next_state          = r_state;
    w_pc_next             = r_pc;
    w_psr_load            = 1'b0;
    w_reg_write           = 1'b0;
    w_mem_write           = 1'b0;
    w_dp_enable           = 1'b0;
    O_MEM_ADDRESS         = r_pc;
    O_MEM_WRITE_DATA      = 16'h0000;
    O_REG_A_SELECT        = w_rs;
    O_REG_B_SELECT        = w_rd;
    O_IMMEDIATE           = 16'h0000;
    O_IMMEDIATE_SELECT    = 1'b0;
    O_OPCODE              = 4'b0000;
    O_REGFILE_DATA_SELECT = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        w_next_state = S_EXECUTE;
      end

      S_EXECUTE: begin
        w_dp_enable  = 1'b1;
        w_next_state = S_FETCH;
        w_pc_next    = w_pc_inc;
        if (w_op[3] == 1'b0) begin
          // R-type (op 0) and I-type (op 1..7) share write and flag rules
          O_OPCODE       = w_alu_opcode;
          O_REG_A_SELECT = w_rs;
          O_REG_B_SELECT = w_rd;
          w_psr_load     = 1'b1;
          w_reg_write    = (w_alu_opcode != P_CMP_OPCODE);
          if (w_op != c_OP_RTYPE) begin
            O_IMMEDIATE        = w_simm;
            O_IMMEDIATE_SELECT = 1'b1;
          end
        end else begin
          case (w_op)
            c_OP_LOAD: begin
              O_REG_B_SELECT = w_rs;
              O_MEM_ADDRESS  = I_REG_B_DATA;
              w_next_state   = S_WRITEBACK;
              w_pc_next      = r_pc;
            end
            c_OP_STORE: begin
              O_REG_A_SELECT   = w_rd;
              O_REG_B_SELECT   = w_rs;
              O_MEM_ADDRESS    = I_REG_B_DATA;
              O_MEM_WRITE_DATA = I_REG_A_DATA;
              w_mem_write      = 1'b1;
            end
            c_OP_BCOND: begin
              if (w_cond) begin
                w_pc_next = r_pc + w_simm;
              end
            end
            c_OP_JCOND: begin
              O_REG_B_SELECT = w_rs;
              if (w_cond) begin
                w_pc_next = I_REG_B_DATA;
              end
            end
            default: begin
              w_pc_next = w_pc_inc;
            end
          endcase
        end
      end

      S_WRITEBACK: begin
        // Address held on rs so the loaded word stays stable across stalls
        w_dp_enable           = 1'b1;
        w_next_state          = S_FETCH;
        w_pc_next             = w_pc_inc;
        O_REG_B_SELECT        = w_rs;
        O_MEM_ADDRESS         = I_REG_B_DATA;
        O_REGFILE_DATA_SELECT = 1'b1;
        w_reg_write           = 1'b1;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign w_active           = I_ENABLE & ~I_RESET;
  assign O_REG_WRITE_ENABLE = (w_reg_write && w_active) ? (16'h0001 << w_rd) : 16'h0000;
  assign O_MEM_WRITE_ENABLE = w_mem_write & w_active;
  assign O_DATAPATH_ENABLE  = w_dp_enable & w_active;
  assign O_PC               = r_pc;
  assign O_FLAGS            = r_psr;
  assign O_STATE            = r_state;

endmodule

`default_nettype wire

// File: tb/tb_controller.sv
// ============================================================================
// Module      : tb_controller
// Description : Self-checking bench for controller: directed sequences plus
//               random instructions against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller;

  localparam logic [15:0] c_RESET_PC = 16'h0000;
  localparam logic [3:0]  c_CMP      = 4'b1011;

  logic        clk = 1'b0;
  logic        I_RESET, I_ENABLE;
  logic [15:0] I_MEM_DATA, I_REG_A_DATA, I_REG_B_DATA;
  logic [4:0]  I_STATUS_FLAGS;
  logic [15:0] O_MEM_ADDRESS, O_MEM_WRITE_DATA, O_REG_WRITE_ENABLE, O_IMMEDIATE, O_PC;
  logic        O_MEM_WRITE_ENABLE, O_IMMEDIATE_SELECT, O_REGFILE_DATA_SELECT, O_DATAPATH_ENABLE;
  logic [3:0]  O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE;
  logic [4:0]  O_FLAGS;
  logic [1:0]  O_STATE;

  logic [15:0] mem [0:255];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_pc;
  logic [4:0]  m_psr;

  always #5 clk = ~clk;

  controller #(.P_RESET_PC(c_RESET_PC), .P_CMP_OPCODE(c_CMP)) dut (
    .I_CLK(clk), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE),
    .I_MEM_DATA(I_MEM_DATA), .I_REG_A_DATA(I_REG_A_DATA), .I_REG_B_DATA(I_REG_B_DATA),
    .I_STATUS_FLAGS(I_STATUS_FLAGS),
    .O_MEM_ADDRESS(O_MEM_ADDRESS), .O_MEM_WRITE_ENABLE(O_MEM_WRITE_ENABLE),
    .O_MEM_WRITE_DATA(O_MEM_WRITE_DATA), .O_REG_WRITE_ENABLE(O_REG_WRITE_ENABLE),
    .O_REG_A_SELECT(O_REG_A_SELECT), .O_REG_B_SELECT(O_REG_B_SELECT),
    .O_IMMEDIATE(O_IMMEDIATE), .O_IMMEDIATE_SELECT(O_IMMEDIATE_SELECT),
    .O_OPCODE(O_OPCODE), .O_REGFILE_DATA_SELECT(O_REGFILE_DATA_SELECT),
    .O_DATAPATH_ENABLE(O_DATAPATH_ENABLE), .O_PC(O_PC), .O_FLAGS(O_FLAGS), .O_STATE(O_STATE)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the memory returns the word addressed before the edge.
  task automatic cycle();
    logic [15:0] a;
    a = O_MEM_ADDRESS;
    @(posedge clk);
    #1;
    I_MEM_DATA = mem[a[7:0]];
    #1;
  endtask

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] p);
    case (c)
      4'd0:  return p[1];
      4'd1:  return !p[1];
      4'd2:  return p[4];
      4'd3:  return !p[4];
      4'd4:  return p[3];
      4'd5:  return !p[3];
      4'd6:  return p[0];
      4'd7:  return !p[0];
      4'd8:  return p[2];
      4'd9:  return !p[2];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic reset_now(input string tag);
    I_RESET = 1'b1;
    #1;
    chk({tag, "_rst_we"}, O_REG_WRITE_ENABLE, 16'h0000);
    chk({tag, "_rst_memwe"}, 16'(O_MEM_WRITE_ENABLE), 16'd0);
    chk({tag, "_rst_dpen"}, 16'(O_DATAPATH_ENABLE), 16'd0);
    cycle();
    I_RESET = 1'b0;
    #1;
    m_pc  = c_RESET_PC;
    m_psr = 5'b00000;
    chk({tag, "_rst_state"}, 16'(O_STATE), 16'd0);
    chk({tag, "_rst_pc"}, O_PC, m_pc);
    chk({tag, "_rst_flags"}, 16'(O_FLAGS), 16'(m_psr));
  endtask

  // rst_at: 0 none, 2 reset during EXECUTE, 3 reset during WRITEBACK.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rb,
                           input logic [4:0] fl, input int stall, input int rst_at);
    logic [3:0]  op, rd, ext, rs, alu_opc;
    logic [15:0] simm, exp_we, exp_pc;
    logic        is_alu, is_load, is_store;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0];
    simm     = {{8{ins[7]}}, ins[7:0]};
    is_alu   = (op <= 4'd7);
    is_load  = (op == 4'd8);
    is_store = (op == 4'd9);
    alu_opc  = (op == 4'd0) ? ext : {1'b0, op[2:0]};
    exp_we   = (is_alu && alu_opc != c_CMP) ? (16'h0001 << rd) : 16'h0000;

    mem[m_pc[7:0]] = ins;
    I_REG_A_DATA = ra; I_REG_B_DATA = rb; I_STATUS_FLAGS = fl;
    #1;
    chk("fetch_state", 16'(O_STATE), 16'd0);
    chk("fetch_addr", O_MEM_ADDRESS, m_pc);
    chk("fetch_dpen", 16'(O_DATAPATH_ENABLE), 16'd0);
    chk("fetch_we", O_REG_WRITE_ENABLE, 16'h0000);
    cycle();
    chk("decode_state", 16'(O_STATE), 16'd1);
    chk("decode_dpen", 16'(O_DATAPATH_ENABLE), 16'd0);
    chk("decode_memwe", 16'(O_MEM_WRITE_ENABLE), 16'd0);
    cycle();
    chk("exec_state", 16'(O_STATE), 16'd2);

    if (stall > 0) begin
      I_ENABLE = 1'b0;
      #1;
      for (int i = 0; i < stall; i++) begin
        chk("stall_memwe", 16'(O_MEM_WRITE_ENABLE), 16'd0);
        chk("stall_we", O_REG_WRITE_ENABLE, 16'h0000);
        chk("stall_pc", O_PC, m_pc);
        chk("stall_flags", 16'(O_FLAGS), 16'(m_psr));
        cycle();
        chk("stall_state", 16'(O_STATE), 16'd2);
      end
      I_ENABLE = 1'b1;
      #1;
    end

    if (rst_at == 2) begin
      reset_now("exec");
      return;
    end

    chk("exec_dpen", 16'(O_DATAPATH_ENABLE), 16'd1);
    chk("exec_we", O_REG_WRITE_ENABLE, exp_we);
    chk("exec_memwe", 16'(O_MEM_WRITE_ENABLE), 16'(is_store));
    if (is_alu) begin
      chk("alu_opcode", 16'(O_OPCODE), 16'(alu_opc));
      chk("alu_immsel", 16'(O_IMMEDIATE_SELECT), 16'(op != 4'd0));
      chk("alu_bsel", 16'(O_REG_B_SELECT), 16'(rd));
      if (op == 4'd0) chk("alu_asel", 16'(O_REG_A_SELECT), 16'(rs));
      else            chk("alu_imm", O_IMMEDIATE, simm);
    end
    if (is_load || is_store) begin
      chk("mem_bsel", 16'(O_REG_B_SELECT), 16'(rs));
      chk("mem_addr", O_MEM_ADDRESS, rb);
    end
    if (is_store) begin
      chk("st_asel", 16'(O_REG_A_SELECT), 16'(rd));
      chk("st_immsel", 16'(O_IMMEDIATE_SELECT), 16'd0);
      chk("st_wdata", O_MEM_WRITE_DATA, ra);
    end
    if (op == 4'd14) chk("j_bsel", 16'(O_REG_B_SELECT), 16'(rs));
    cycle();

    if (is_load) begin
      chk("wb_state", 16'(O_STATE), 16'd3);
      if (rst_at == 3) begin
        reset_now("wb");
        return;
      end
      chk("wb_datasel", 16'(O_REGFILE_DATA_SELECT), 16'd1);
      chk("wb_we", O_REG_WRITE_ENABLE, 16'h0001 << rd);
      chk("wb_memwe", 16'(O_MEM_WRITE_ENABLE), 16'd0);
      cycle();
    end

    if (op == 4'd12 && cond_true(rd, m_psr))      exp_pc = m_pc + simm;
    else if (op == 4'd14 && cond_true(rd, m_psr)) exp_pc = rb;
    else                                          exp_pc = m_pc + 16'd1;
    if (is_alu) m_psr = fl;
    m_pc = exp_pc;
    chk("done_state", 16'(O_STATE), 16'd0);
    chk("done_pc", O_PC, m_pc);
    chk("done_flags", 16'(O_FLAGS), 16'(m_psr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
    I_RESET = 1'b1; I_ENABLE = 1'b1; I_MEM_DATA = 16'h0000;
    I_REG_A_DATA = 16'h0000; I_REG_B_DATA = 16'h0000; I_STATUS_FLAGS = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 16'(O_STATE), 16'd0);
    chk("reset_pc", O_PC, c_RESET_PC);
    chk("reset_flags", 16'(O_FLAGS), 16'd0);
    chk("reset_we", O_REG_WRITE_ENABLE, 16'h0000);
    chk("reset_dpen", 16'(O_DATAPATH_ENABLE), 16'd0);
    I_RESET = 1'b0;
    #1;
    m_pc = c_RESET_PC; m_psr = 5'b00000;

    run_instr(16'h0352, 16'h1111, 16'h2222, 5'b10101, 0, 0); // ADD r3 <- r2
    run_instr(16'h53FF, 16'h0000, 16'h0000, 5'b00001, 0, 0); // I-type, imm -1
    run_instr(16'h01B2, 16'h0000, 16'h0000, 5'b00010, 0, 0); // CMP sets Z
    run_instr(16'hA000, 16'h0000, 16'h0000, 5'b11111, 0, 0);
    run_instr(16'hF123, 16'h0000, 16'h0000, 5'b11111, 0, 0);
    run_instr(16'hC0FE, 16'h0000, 16'h0000, 5'b00000, 0, 0); // BEQ taken: 5 -> 3
    run_instr(16'h01B2, 16'h0000, 16'h0000, 5'b00000, 0, 0); // CMP clears Z
    run_instr(16'hA000, 16'h0000, 16'h0000, 5'b00000, 0, 0);
    run_instr(16'hC0FE, 16'h0000, 16'h0000, 5'b00010, 0, 0); // BEQ not taken: 5 -> 6
    run_instr(16'h8102, 16'h0000, 16'h0040, 5'b00000, 0, 0); // LOAD
    run_instr(16'h9312, 16'hBEEF, 16'h0080, 5'b00000, 2, 0); // STORE stalled 2
    run_instr(16'hEE00, 16'h0000, 16'hFFFF, 5'b00000, 0, 0); // JUC to FFFF
    run_instr(16'hD000, 16'h0000, 16'h0000, 5'b00000, 0, 0); // NOP wraps to 0
    run_instr(16'hC4F0, 16'h0000, 16'h0000, 5'b00000, 0, 0); // BHI !L: not taken
    run_instr(16'hCEF0, 16'h0000, 16'h0000, 5'b00000, 0, 0); // BUC below zero wraps
    run_instr(16'h8102, 16'h0000, 16'h0040, 5'b00000, 0, 3); // reset in WRITEBACK
    run_instr(16'h9A45, 16'h1234, 16'h0010, 5'b00000, 0, 2); // reset in STORE EXECUTE

    for (int n = 0; n < 80; n++) begin
      logic [15:0] ins, ra, rb;
      logic [4:0]  fl;
      int          st;
      ins = 16'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      fl  = 5'($urandom);
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_instr(ins, ra, rb, fl, st, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter P_RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter P_CMP_OPCODE, default 4'b1011, is the ALU opcode whose result is flags-only, with no register write.
REQ-003 I_CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 I_RESET  in  1  synchronous active-high reset.
REQ-005 I_ENABLE  in  1  low: all state frozen, O_REG_WRITE_ENABLE=0, O_MEM_WRITE_ENABLE=0.
REQ-006 I_MEM_DATA  in  16  synchronous-read memory data, valid one cycle after O_MEM_ADDRESS.
REQ-007 I_REG_A_DATA / I_REG_B_DATA  in  16 each  datapath O_A / O_B.
REQ-008 I_STATUS_FLAGS  in  5  datapath ALU flags: [4]=C, [3]=L, [2]=F, [1]=Z, [0]=N.
REQ-009 O_MEM_ADDRESS  out  16 and O_MEM_WRITE_ENABLE  out  1 and O_MEM_WRITE_DATA  out  16 form the memory port.
REQ-010 O_REG_WRITE_ENABLE  out  16  one-hot regfile write strobe.
REQ-011 O_REG_A_SELECT, O_REG_B_SELECT  out  4 each  are the regfile read selects.
REQ-012 O_IMMEDIATE  out  16 and O_IMMEDIATE_SELECT  out  1 drive the ALU 'A' immediate.
REQ-013 O_OPCODE  out  4 is the ALU opcode; O_REGFILE_DATA_SELECT  out  1 set means memory data is written to the regfile.
REQ-014 O_DATAPATH_ENABLE  out  1 is the datapath I_ENABLE; O_PC  out  16; O_FLAGS  out  5 is the latched PSR; O_STATE  out  2.

Function
REQ-015 IR fields: op=IR[15:12], rd=IR[11:8], ext=IR[7:4], rs=IR[3:0], imm8=IR[7:0].
REQ-016 Opcodes:
- 0000 R-type
- 0001-0111 I-type
- 1000 LOAD
- 1001 STORE
- 1100 Bcond
- 1110 Jcond
- others are NOP (PC+1)
REQ-017 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3; O_STATE shows the state.
REQ-018 FETCH: O_MEM_ADDRESS=PC; next state DECODE.
REQ-019 DECODE: IR<=I_MEM_DATA; next state EXECUTE.
REQ-020 EXECUTE: next state WRITEBACK for LOAD, FETCH for all other instructions.
REQ-021 WRITEBACK: next state FETCH.
REQ-022 O_DATAPATH_ENABLE=1 only in EXECUTE and WRITEBACK.
REQ-023 In other states, all write strobes SHALL be 0.
REQ-024 R-type EXECUTE:
- A=rs, B=rd, O_OPCODE=ext, O_IMMEDIATE_SELECT=0
- writes rd unless ext==P_CMP_OPCODE
- PSR<=I_STATUS_FLAGS
- PC<=PC+1
REQ-025 I-type EXECUTE:
- O_OPCODE={0,op[2:0]}, O_IMMEDIATE=sign-extended imm8, O_IMMEDIATE_SELECT=1
- B=rd, write rules as REQ-024
- PSR<=I_STATUS_FLAGS
- PC<=PC+1
REQ-026 LOAD:
- EXECUTE: B=rs, O_MEM_ADDRESS=I_REG_B_DATA
- WRITEBACK: O_REGFILE_DATA_SELECT=1, rd written, PC<=PC+1
REQ-027 STORE EXECUTE:
- A=rd, B=rs, O_IMMEDIATE_SELECT=0
- O_MEM_ADDRESS=I_REG_B_DATA, O_MEM_WRITE_DATA=I_REG_A_DATA, O_MEM_WRITE_ENABLE=1
- PC<=PC+1
REQ-028 Condition codes (rd field):
- 0 EQ Z, 1 NE !Z
- 2 CS C, 3 CC !C
- 4 HI L, 5 LS !L
- 6 GT N, 7 LE !N
- 8 FS F, 9 FC !F
- 14 UC always
- all others never
REQ-029 Conditions SHALL be evaluated on the PSR value held at the start of EXECUTE.
REQ-030 Bcond: if the condition is true, PC<=PC+sign-extended imm8; otherwise PC<=PC+1.
REQ-031 Jcond: B=rs; if the condition is true, PC<=I_REG_B_DATA; otherwise PC<=PC+1.
REQ-032 Only ALU instructions modify the PSR.
REQ-033 PC arithmetic SHALL be modulo 2^16: 16'hFFFF+1=16'h0000; a branch below zero wraps.
REQ-034 Latency: ALU/STORE/branch/NOP take 3 cycles; LOAD takes 4.
REQ-035 At most one O_REG_WRITE_ENABLE bit SHALL be set in any cycle.
REQ-036 I_ENABLE low mid-instruction: hold state/PC/IR/PSR; resume in the same state when it returns high.

Reset
REQ-037 While I_RESET=1 on an edge:
- state<=FETCH, PC<=P_RESET_PC, IR<=0, PSR<=0
- all write strobes 0, O_DATAPATH_ENABLE=0
REQ-038 Reset SHALL take priority over I_ENABLE and over any in-flight instruction, including a WRITEBACK or a store in progress.
REQ-039 Reset asserted during STORE EXECUTE SHALL suppress O_MEM_WRITE_ENABLE in that cycle.

Verification
REQ-040 Reset, then memory[0]=16'h0352 (R-type ADD): O_STATE sequence 0,1,2; in EXECUTE, O_REG_WRITE_ENABLE=16'h0008, A=2, B=3; PC=1.
REQ-041 I-type 16'h53FF (op=0101, imm=-1): O_IMMEDIATE=16'hFFFF, O_IMMEDIATE_SELECT=1, O_OPCODE=4'b0101.
REQ-042 CMP with ext=1011: no write strobe; PSR updated; following BEQ 16'hC0FE (Z=1) at PC=5: PC=3; with Z=0: PC=6.
REQ-043 LOAD 16'h8102 with I_REG_B_DATA=16'h0040: O_MEM_ADDRESS=16'h0040 in EXECUTE; O_REGFILE_DATA_SELECT=1 and strobe 16'h0002 in WRITEBACK; 4 cycles total.
REQ-044 STORE with I_ENABLE dropped for 2 cycles in EXECUTE: O_MEM_WRITE_ENABLE=0 while low; exactly one write after I_ENABLE returns high.
REQ-045 PC=16'hFFFF executing a NOP: next PC=16'h0000; reset mid-LOAD WRITEBACK: no register write, PC=P_RESET_PC.
